// File: rtl/multi_bounce_filter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : multi_bounce_filter_pkg
// Description : Shared helpers for the multi-channel debounce filter:
//               integrator ceiling derivation and parameter legality check.
// Revision    : 1.0 - initial release
// ============================================================================
package multi_bounce_filter_pkg;

    // Saturation ceiling of a CNT_W-bit integrator.
    function automatic int cnt_max_f(input int cnt_w);
        return (1 << cnt_w) - 1;
    endfunction

    // True when the threshold/prescale/width combination is usable.
    function automatic bit params_legal_f(
        input int channels,
        input int cnt_w,
        input int th_hi,
        input int th_lo,
        input int sync_stages,
        input int prescale
    );
        return (channels >= 1) && (cnt_w >= 2) && (cnt_w <= 30) &&
               (th_lo >= 0) && (th_lo < th_hi) && (th_hi <= cnt_max_f(cnt_w)) &&
               (sync_stages >= 0) && (prescale >= 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/multi_bounce_filter_bounce_channel.sv
`default_nettype none
// ============================================================================
// Module      : bounce_channel
// Description : One filtered line: synchroniser, saturating up/down
//               integrator, two-threshold hysteresis and registered
//               rise/fall pulses.
// Ports       : clk, rst_n (async, active low), tick (integrate strobe),
//               in (raw line), out (filtered level), rise/fall (1-clk pulses)
// Revision    : 1.0 - initial release
// ============================================================================
module bounce_channel
    import multi_bounce_filter_pkg::*;
#(
    parameter int   CNT_W       = 5,
    parameter int   TH_HI       = 24,
    parameter int   TH_LO       = 7,
    parameter int   SYNC_STAGES = 2,
    parameter logic INIT        = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick,
    input  logic in,
    output logic out,
    output logic rise,
    output logic fall
);

    localparam logic [CNT_W-1:0] c_cnt_max = CNT_W'(cnt_max_f(CNT_W));
    localparam logic [CNT_W-1:0] c_th_hi   = CNT_W'(TH_HI);
    localparam logic [CNT_W-1:0] c_th_lo   = CNT_W'(TH_LO);

    logic w_s;

    // Synchroniser: new sample enters the LSB, last stage is the MSB.
    generate
        if (SYNC_STAGES == 0) begin : g_no_sync
            assign w_s = in;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0] r_sync_q;
            logic [SYNC_STAGES-1:0] w_sync_d;
            logic [SYNC_STAGES:0]   w_shift;

            always_comb begin
                w_shift  = {r_sync_q, in};
                w_sync_d = w_shift[SYNC_STAGES-1:0];
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_sync_q <= {SYNC_STAGES{INIT}};
                end else begin
                    r_sync_q <= w_sync_d;
                end
            end

            assign w_s = r_sync_q[SYNC_STAGES-1];
        end
    endgenerate

    logic [CNT_W-1:0] r_cnt_q;
    logic [CNT_W-1:0] w_cnt_d;
    logic             r_out_q;
    logic             w_out_d;
    logic             r_rise_q;
    logic             w_rise_d;
    logic             r_fall_q;
    logic             w_fall_d;

    always_comb begin
        w_cnt_d = r_cnt_q;
        if (tick) begin
            if (w_s && (r_cnt_q != c_cnt_max)) begin
                w_cnt_d = r_cnt_q + 1'b1;
            end else if (!w_s && (r_cnt_q != '0)) begin
                w_cnt_d = r_cnt_q - 1'b1;
            end
        end

        // Thresholds act on the post-update count so out moves on the
        // same edge the integrator crosses them.
        w_out_d = r_out_q;
        if (tick) begin
            if (w_cnt_d >= c_th_hi) begin
                w_out_d = 1'b1;
            end else if (w_cnt_d <= c_th_lo) begin
                w_out_d = 1'b0;
            end
        end

        w_rise_d = w_out_d & ~r_out_q;
        w_fall_d = ~w_out_d & r_out_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt_q  <= INIT ? c_cnt_max : '0;
            r_out_q  <= INIT;
            r_rise_q <= 1'b0;
            r_fall_q <= 1'b0;
        end else begin
            r_cnt_q  <= w_cnt_d;
            r_out_q  <= w_out_d;
            r_rise_q <= w_rise_d;
            r_fall_q <= w_fall_d;
        end
    end

    assign out  = r_out_q;
    assign rise = r_rise_q;
    assign fall = r_fall_q;

endmodule
`default_nettype wire

// File: rtl/multi_bounce_filter.sv
`default_nettype none
// ============================================================================
// Module      : multi_bounce_filter
// Description : Multi-channel debounce / glitch filter. Holds the shared
//               integration prescaler and one bounce_channel per line.
// Ports       : clk, rst_n (async, active low), en (freeze when 0),
//               in[CHANNELS] raw lines, out[CHANNELS] filtered levels,
//               rise/fall[CHANNELS] one-clock event pulses, tick (strobe)
// Revision    : 1.0 - initial release
// ============================================================================
module multi_bounce_filter
    import multi_bounce_filter_pkg::*;
#(
    parameter int                  CHANNELS    = 2,
    parameter int                  CNT_W       = 5,
    parameter int                  TH_HI       = 24,
    parameter int                  TH_LO       = 7,
    parameter int                  SYNC_STAGES = 2,
    parameter int                  PRESCALE    = 1,
    parameter logic [CHANNELS-1:0] INIT        = {CHANNELS{1'b1}}
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic [CHANNELS-1:0] in,
    output logic [CHANNELS-1:0] out,
    output logic [CHANNELS-1:0] rise,
    output logic [CHANNELS-1:0] fall,
    output logic                tick
);

    generate
        if (!params_legal_f(CHANNELS, CNT_W, TH_HI, TH_LO, SYNC_STAGES, PRESCALE)) begin : g_param_check
            $error("multi_bounce_filter: illegal parameter combination");
        end
    endgenerate

    localparam int                 c_pre_w    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [c_pre_w-1:0] c_pre_last = c_pre_w'(PRESCALE - 1);

    logic [c_pre_w-1:0] r_pre_q;
    logic [c_pre_w-1:0] w_pre_d;
    logic               w_pre_wrap;

    assign w_pre_wrap = (r_pre_q == c_pre_last);

    always_comb begin
        w_pre_d = r_pre_q;
        if (en) begin
            w_pre_d = w_pre_wrap ? '0 : r_pre_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pre_q <= '0;
        end else begin
            r_pre_q <= w_pre_d;
        end
    end

    // Qualified with rst_n so the strobe is quiet while reset is held.
    assign tick = en & rst_n & w_pre_wrap;

    generate
        for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
            bounce_channel #(
                .CNT_W       (CNT_W),
                .TH_HI       (TH_HI),
                .TH_LO       (TH_LO),
                .SYNC_STAGES (SYNC_STAGES),
                .INIT        (INIT[i])
            ) u_chan (
                .clk   (clk),
                .rst_n (rst_n),
                .tick  (tick),
                .in    (in[i]),
                .out   (out[i]),
                .rise  (rise[i]),
                .fall  (fall[i])
            );
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_multi_bounce_filter.sv
`default_nettype none
// ============================================================================
// Module      : tb_multi_bounce_filter
// Description : Directed self-checking bench for multi_bounce_filter.
//               dut  : CNT_W=4, TH_HI=12, TH_LO=3, SYNC=2, PRESCALE=1
//               dut4 : same thresholds, PRESCALE=4
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multi_bounce_filter;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic       en    = 1'b1;
    logic [1:0] in    = 2'b10;
    logic [1:0] out, rise, fall;
    logic       tick;

    logic       en4   = 1'b1;
    logic [1:0] in4   = 2'b10;
    logic [1:0] out4, rise4, fall4;
    logic       tick4;

    int checks   = 0;
    int failures = 0;
    int rise_n0 = 0, rise_n1 = 0, fall_n0 = 0, fall_n1 = 0;

    always #5 clk = ~clk;

    multi_bounce_filter #(
        .CHANNELS(2), .CNT_W(4), .TH_HI(12), .TH_LO(3),
        .SYNC_STAGES(2), .PRESCALE(1), .INIT(2'b10)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .in(in),
        .out(out), .rise(rise), .fall(fall), .tick(tick)
    );

    multi_bounce_filter #(
        .CHANNELS(2), .CNT_W(4), .TH_HI(12), .TH_LO(3),
        .SYNC_STAGES(2), .PRESCALE(4), .INIT(2'b10)
    ) dut4 (
        .clk(clk), .rst_n(rst_n), .en(en4), .in(in4),
        .out(out4), .rise(rise4), .fall(fall4), .tick(tick4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance n rising edges, settle 1 time unit, tally event pulses.
    task automatic clk_n(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            rise_n0 += int'(rise[0]);
            rise_n1 += int'(rise[1]);
            fall_n0 += int'(fall[0]);
            fall_n1 += int'(fall[1]);
        end
    endtask

    task automatic clr_counts();
        rise_n0 = 0; rise_n1 = 0; fall_n0 = 0; fall_n1 = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // ---- asynchronous reset, no clock edge yet ----
        #1;
        in    = 2'b01;
        rst_n = 1'b0;
        #1;
        chk("rst_out",   out,  2'b10);
        chk("rst_rise",  rise, 2'b00);
        chk("rst_fall",  fall, 2'b00);
        chk("rst_cnt0",  dut.g_ch[0].u_chan.r_cnt_q, 0);
        chk("rst_cnt1",  dut.g_ch[1].u_chan.r_cnt_q, 15);
        chk("rst_tick",  tick, 0);
        chk("rst_out4",  out4, 2'b10);

        clk_n(3);
        in    = 2'b10;
        rst_n = 1'b1;
        clr_counts();
        clk_n(50);
        chk("idle_pulses", rise_n0 + rise_n1 + fall_n0 + fall_n1, 0);
        chk("idle_out",    out, 2'b10);
        chk("tick_p1",     tick, 1);

        // ---- ch0 rise: out goes high after edge 14 ----
        in[0] = 1'b1;
        clk_n(13);
        chk("rise_pre_out", out[0], 0);
        clk_n(1);
        chk("rise_out",   out[0], 1);
        chk("rise_pulse", rise[0], 1);
        clk_n(1);
        chk("rise_single", rise[0], 0);
        clk_n(10);
        chk("rise_sat",   dut.g_ch[0].u_chan.r_cnt_q, 15);
        chk("rise_count", rise_n0, 1);

        // ---- ch1 glitch of 6 clocks ----
        in[1] = 1'b0;
        clk_n(6);
        in[1] = 1'b1;
        clk_n(2);
        chk("glitch_min", dut.g_ch[1].u_chan.r_cnt_q, 9);
        chk("glitch_out", out[1], 1);
        clk_n(6);
        chk("glitch_back", dut.g_ch[1].u_chan.r_cnt_q, 15);
        clk_n(4);
        chk("glitch_nofall", fall_n1, 0);

        // ---- ch1 sustained low ----
        in[1] = 1'b0;
        clk_n(13);
        chk("fall_pre_out", out[1], 1);
        clk_n(1);
        chk("fall_out",   out[1], 0);
        chk("fall_pulse", fall[1], 1);
        chk("fall_cnt",   dut.g_ch[1].u_chan.r_cnt_q, 3);
        clk_n(5);
        chk("fall_count", fall_n1, 1);

        // ---- hysteresis: ch0 brought to 3, then toggled ----
        in[0] = 1'b0;
        clk_n(14);
        chk("hyst_setup_out", out[0], 0);
        chk("hyst_setup_cnt", dut.g_ch[0].u_chan.r_cnt_q, 3);
        clr_counts();
        for (int k = 0; k < 100; k++) begin
            in[0] = ~in[0];
            clk_n(1);
        end
        chk("hyst_out",    out[0], 0);
        chk("hyst_pulses", rise_n0 + fall_n0, 0);
        chk("hyst_band",   32'(dut.g_ch[0].u_chan.r_cnt_q <= 4'd3), 1);

        // ---- reset asserted mid-ramp ----
        in[0] = 1'b0;
        clk_n(20);
        in[0] = 1'b1;
        clk_n(10);
        chk("mid_cnt0", dut.g_ch[0].u_chan.r_cnt_q, 8);
        clr_counts();
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_cnt0", dut.g_ch[0].u_chan.r_cnt_q, 0);
        chk("mid_rst_cnt1", dut.g_ch[1].u_chan.r_cnt_q, 15);
        chk("mid_rst_out",  out, 2'b10);
        chk("mid_rst_ev",   {rise, fall}, 4'b0000);
        clk_n(3);
        in    = 2'b10;
        rst_n = 1'b1;
        clk_n(20);
        chk("mid_rst_pulses", rise_n0 + rise_n1 + fall_n0 + fall_n1, 0);
        chk("mid_rst_out2",   out, 2'b10);

        // ---- prescale 4 with enable drop ----
        for (int k = 0; k < 8 && !tick4; k++) clk_n(1);
        chk("p4_tick_found", tick4, 1);
        clk_n(1); chk("p4_tick_g1", tick4, 0);
        clk_n(1); chk("p4_tick_g2", tick4, 0);
        clk_n(1); chk("p4_tick_g3", tick4, 0);
        clk_n(1); chk("p4_tick_on", tick4, 1);
        in4[0] = 1'b1;
        clk_n(20);
        chk("p4_cnt_pre", dut4.g_ch[0].u_chan.r_cnt_q, 4);
        en4 = 1'b0;
        clk_n(10);
        chk("p4_frz_tick", tick4, 0);
        chk("p4_frz_cnt",  dut4.g_ch[0].u_chan.r_cnt_q, 4);
        clk_n(10);
        en4 = 1'b1;
        clk_n(28);
        chk("p4_pre_out", out4[0], 0);
        clk_n(1);
        chk("p4_out",     out4[0], 1);
        chk("p4_rise",    rise4[0], 1);
        clk_n(1);
        chk("p4_rise_end", rise4[0], 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/multi_bounce_filter.md
Name: multi_bounce_filter

Overview:
- Multi-channel debounce/glitch filter for slow external lines: I2C SCL/SDA, buttons, open-drain status pins.
- Per channel: input synchroniser, saturating up/down integrator, hysteresis comparator with two thresholds, and registered rise/fall event pulses.
- A shared prescaler sets the integration rate.
- Sits between the pads and the I2C bus controllers / GPIO capture logic.

Parameters:
- CHANNELS, 2, number of independent filtered lines (>=1)
- CNT_W, 5, integrator width; CNT_MAX = 2^CNT_W-1 (>=2)
- TH_HI, 24, output switches to 1 when integrator >= TH_HI
- TH_LO, 7, output switches to 0 when integrator <= TH_LO; legal range 0 <= TH_LO < TH_HI <= CNT_MAX
- SYNC_STAGES, 2, synchroniser flops per channel; 0 = input used directly
- PRESCALE, 1, integrator updates once every PRESCALE clocks (>=1)
- INIT, {CHANNELS{1'b1}}, per-channel idle/reset level (I2C idles high)

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- en  in  1  filter enable; 0 freezes prescaler and integrators
- in  in  CHANNELS  raw asynchronous inputs
- out  out  CHANNELS  filtered levels
- rise  out  CHANNELS  one-clock pulse on 0->1 of out
- fall  out  CHANNELS  one-clock pulse on 1->0 of out
- tick  out  1  prescaler strobe (debug/observability)

Behaviour:
- Reset (rst_n=0, asynchronous, immediate):
  - sync flops[i] = INIT[i]
  - cnt[i] = INIT[i] ? CNT_MAX : 0
  - out = INIT
  - rise = fall = 0
  - prescaler = 0, tick = 0
- Deassertion takes effect at the first clk edge with rst_n=1.
- Reset asserted mid-operation discards all integration state; no rise/fall pulse is generated by reset itself.
- Synchroniser: chain of SYNC_STAGES flops per channel, always clocked (not gated by en). s[i] is the last stage.
- Prescaler: counter 0..PRESCALE-1, advances only when en=1. tick is combinational, high in the cycle the counter equals PRESCALE-1 and en=1; the counter wraps to 0 on that edge. PRESCALE=1 gives tick=en every cycle.
- Integrator, on an edge where tick=1:
  - s[i]=1 and cnt<CNT_MAX: cnt+1
  - s[i]=0 and cnt>0: cnt-1
  - otherwise hold (saturation at both ends; no wrap).
  - Without tick, cnt holds.
- Hysteresis, evaluated on the same edge from the next value cnt_n:
  - cnt_n >= TH_HI: out <= 1
  - cnt_n <= TH_LO: out <= 0
  - otherwise out holds
  - out therefore changes on the same edge the threshold is crossed.
- Events: rise[i]/fall[i] are registered and high for exactly the one clock following the edge where out[i] changed. They are 0 on all other cycles, including while en=0.
- Latency (PRESCALE=1, en=1, cnt starting at 0, in held high before edge 1): out=1 after edge SYNC_STAGES+TH_HI. From CNT_MAX, out=0 after edge SYNC_STAGES+(CNT_MAX-TH_LO).
- Pulses shorter than the threshold distance leave out unchanged. Alternating input inside the band (TH_LO, TH_HI) never toggles out.
- Channels are fully independent; they share only the prescaler/tick.
- en falling mid-integration: cnt and out freeze; integration resumes from the frozen value. Prescaler phase is preserved.

Decomposition:
- Shared package/header holds:
  - CNT_MAX derivation
  - parameter legality checks: TH_LO<TH_HI<=CNT_MAX, PRESCALE>=1, CNT_W>=2; elaboration error when violated
- Natural sub-module: bounce_channel (synchroniser + integrator + hysteresis + edge pulses), instantiated CHANNELS times by a generate loop.
- The top holds only the prescaler.

Test Plan:
All scenarios use CNT_W=4, TH_HI=12, TH_LO=3, SYNC_STAGES=2, PRESCALE=1, CHANNELS=2, INIT=2'b10 unless stated.
- Reset: rst_n=0 with arbitrary in -> out=2'b10, cnt0=0, cnt1=15, rise=fall=0 immediately (no clk). After release with in=2'b10 held for 50 clocks -> no pulses.
- Rise: ch0 in 0->1 sampled at edge 1 -> out[0]=1 after edge 14, rise[0]=1 for exactly one clock. Further cnt0 saturates at 15.
- Glitch reject: ch1 low for 6 clocks -> cnt1 drops to 9 then returns to 15, out[1] stays 1. A low held 12+ clocks -> fall[1] pulse, out[1]=0 after edge 14.
- Hysteresis: ch0 driven with cnt at 3, then in toggling 1/0 every clock for 100 clocks -> out[0] stays 0, no pulses.
- Prescale/enable: PRESCALE=4 -> tick every 4th clock, rise needs 12 ticks (≈48 clocks + sync). Drop en for 20 clocks mid-ramp -> cnt and tick frozen, completion delayed by exactly 20 clocks.
- Reset mid-ramp: assert rst_n=0 with cnt0=8 -> cnt0=0, out restored to INIT asynchronously, no rise/fall emitted.
